lifo_arbiter: RTL and testbench
===============================

// Module: lifo_arbiter
//
// PURPOSE
//  Sequencer/arbiter sharing one LIFO stack between two requesters (0: microsequencer, 1: console/debug).
//  Accepts push, pop, exchange (replace top) and clear commands over a req/ack handshake.
//  Grants round-robin and drives the stack's clken/clr/push/pop/in strobes.
//  Returns popped data and an error status; exchange is built as a sequenced pop-then-push.
//
// PARAMETERS
//  WIDTH   36   data word width; must match the attached stack's WIDTH
//
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-high
//  req0/req1   in   1      command request, held high until matching ack
//  op0/op1     in   2      00 push, 01 pop, 10 exchange, 11 clear
//  wdata0/1    in   WIDTH  push/exchange data; must be stable while req high
//  ack0/ack1   out  1      one-cycle completion pulse
//  err0/err1   out  1      error status, valid only while ackN is high
//  rdata       out  WIDTH  popped word (pop/exchange); held until the next pop/exchange completes
//  busy        out  1      high in every state except IDLE
//  lifo_clken  out  1      stack clock enable
//  lifo_clr    out  1      stack clear
//  lifo_push   out  1      stack push
//  lifo_pop    out  1      stack pop
//  lifo_in     out  WIDTH  stack write data
//  lifo_out    in   WIDTH  stack top-of-stack (combinational read)
//  lifo_full   in   1      stack full
//  lifo_empty  in   1      stack empty
//
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0 (requester 0 wins first tie).
//    ack*, err*, busy, lifo_* strobes, lifo_in and rdata all 0.
//    Reset mid-operation abandons the command with no ack.
//  - All outputs registered. No stack strobe outside EXEC/XPUSH; lifo_clken=1 only in those states.
//  - States: IDLE -> EXEC -> [XPUSH] -> DONE -> IDLE.
//  - IDLE: sample req0/req1.
//    - One request pending: grant it.
//    - Both pending: grant the one not granted last, then flip rr.
//    - Latch op and wdata; go to EXEC.
//  - EXEC: perform one stack cycle by op.
//    - push: lifo_push=1, lifo_in=wdata.
//    - pop: lifo_pop=1; capture rdata <= lifo_out.
//    - clear: lifo_clr=1.
//    - exchange: lifo_pop=1, rdata <= lifo_out; go to XPUSH.
//  - XPUSH: lifo_push=1, lifo_in=wdata. Net result: top replaced, depth unchanged.
//  - DONE: ackN=1 for one cycle to the granted requester, errN set per rules below; return to IDLE.
//  - Latency from req sampled in IDLE to ack: push/pop/clear 3 cycles, exchange 4 cycles.
//  - After ack, a req still high is a new command (earliest sampled in the IDLE cycle after DONE).
//  - The stack is never driven with push and pop in the same cycle.
//  - Pop or exchange with lifo_empty=1 at EXEC:
//    - no strobe; rdata unchanged; go straight to DONE with err=1.
//  - Push at EXEC with lifo_full=1: governed by CONFIGURATION.
//  - Exchange on a full stack is legal: pop then push never exceeds depth.
//  - Clear always succeeds (err=0). Requester 1 clear also discards requester 0's stacked data; no protection.
//  - The non-granted requester's req is ignored until the next IDLE cycle.
//
// CONFIGURATION
//  LIFO_ARBITER_OVFPROT_EN
//  - Defined: push with lifo_full=1 issues no strobe; DONE with err=1; stack contents unchanged.
//  - Undefined: push on full is issued. The stack overwrites its oldest entry; err=0.
//
// TESTING
//  1 push 0x123456789 via req0, then pop via req0 -> ack0 3 cycles after each req; rdata=0x123456789; err0=0.
//  2 req0 and req1 both high, each repeats push 4x -> grants strictly alternate, 0 first after reset; 8 acks total.
//  3 push A, push B, exchange C, pop, pop -> exchange rdata=B, ack at 4 cycles; later pops return C then A.
//  4 pop on empty stack -> err=1 with ack; lifo_pop never asserted; rdata unchanged.
//  5 fill to lifo_full, push D -> OVFPROT_EN: err=1, no lifo_push; else err=0, lifo_push pulses once.
//  6 rst asserted in XPUSH -> next cycle all outputs 0, state IDLE, no ack; clear op -> lifo_clr one cycle, empty=1.

Source files
------------

// File: rtl/lifo_arbiter_if.sv
// lifo_arbiter_if
//   Requester-side command bus of the LIFO arbiter. Two requesters share it:
//   requester 0 (microsequencer) and requester 1 (console/debug).
//
//   Signals (directions seen from the arbiter, i.e. the slave modport):
//     req0/req1     in   command request, held high until the matching ack
//     op0/op1       in   00 push, 01 pop, 10 exchange, 11 clear
//     wdata0/wdata1 in   push/exchange data, stable while req is high
//     ack0/ack1     out  one-cycle completion pulse
//     err0/err1     out  error status, meaningful only while ack is high
//     rdata         out  last popped word (pop/exchange)
//     busy          out  arbiter is working on a command
//
//   master: requester side. slave: arbiter side.
interface lifo_arbiter_if #(
    parameter int WIDTH = 36
);
    logic             req0;
    logic             req1;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             ack0;
    logic             ack1;
    logic             err0;
    logic             err1;
    logic [WIDTH-1:0] rdata;
    logic             busy;

    modport master (
        output req0, req1, op0, op1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata, busy
    );

    modport slave (
        input  req0, req1, op0, op1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata, busy
    );
endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter
//   Shares one LIFO stack between two requesters. Commands (push, pop,
//   exchange, clear) arrive over the req/ack bus in lifo_arbiter_if; ties are
//   broken round-robin, starting with requester 0 after reset. Exchange is a
//   pop followed by a push, replacing the top word without changing depth.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     bus           lifo_arbiter_if.slave requester bus
//     o_lifo_clken  stack clock enable (only in EXEC/XPUSH)
//     o_lifo_clr    stack clear strobe
//     o_lifo_push   stack push strobe
//     o_lifo_pop    stack pop strobe
//     o_lifo_in     stack write data
//     i_lifo_out    stack top-of-stack (combinational read)
//     i_lifo_full   stack full
//     i_lifo_empty  stack empty
//
//   Configuration macro: LIFO_ARBITER_OVFPROT_EN
//     defined   - push on a full stack is refused: no strobe, err=1
//     undefined - push on a full stack is issued (stack drops its oldest), err=0
module lifo_arbiter #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    lifo_arbiter_if.slave    bus,
    output logic             o_lifo_clken,
    output logic             o_lifo_clr,
    output logic             o_lifo_push,
    output logic             o_lifo_pop,
    output logic [WIDTH-1:0] o_lifo_in,
    input  logic [WIDTH-1:0] i_lifo_out,
    input  logic             i_lifo_full,
    input  logic             i_lifo_empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        XPUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_XCH  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_wdata;
    logic             r_grant;
    logic             r_rr;
    logic             r_err;
    logic [1:0]       r_ack;
    logic [1:0]       r_errOut;
    logic [WIDTH-1:0] r_rdata;
    logic             r_busy;
    logic             r_clken;
    logic             r_clr;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_lifoIn;

    state_t           w_stateNext;
    op_t              w_opNext;
    logic [WIDTH-1:0] w_wdataNext;
    logic             w_grantNext;
    logic             w_rrNext;
    logic             w_errNext;
    logic [1:0]       w_ack;
    logic [1:0]       w_errOut;
    logic             w_clken;
    logic             w_clr;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_lifoIn;
    logic             w_capture;
    logic             w_pushBlocked;

`ifdef LIFO_ARBITER_OVFPROT_EN
    assign w_pushBlocked = i_lifo_full;
`else
    logic w_unusedFull;
    assign w_unusedFull  = i_lifo_full;
    assign w_pushBlocked = 1'b0;
`endif

    // Every output is a register, so the strobes for a state are computed one
    // cycle ahead, during the transition into it. The stack is never strobed in
    // IDLE, so full/empty seen in IDLE still hold during EXEC.
    always_comb begin
        w_stateNext = r_state;
        w_opNext    = r_op;
        w_wdataNext = r_wdata;
        w_grantNext = r_grant;
        w_rrNext    = r_rr;
        w_errNext   = r_err;
        w_ack       = 2'b00;
        w_errOut    = 2'b00;
        w_clken     = 1'b0;
        w_clr       = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_lifoIn    = '0;
        w_capture   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // r_rr names the requester that wins the next tie.
                    w_grantNext = (bus.req0 && bus.req1) ? r_rr : bus.req1;
                    w_rrNext    = ~w_grantNext;
                    w_opNext    = op_t'(w_grantNext ? bus.op1 : bus.op0);
                    w_wdataNext = w_grantNext ? bus.wdata1 : bus.wdata0;
                    w_errNext   = 1'b0;
                    w_clken     = 1'b1;
                    case (w_opNext)
                        OP_PUSH: begin
                            if (w_pushBlocked) begin
                                w_errNext = 1'b1;
                            end else begin
                                w_push   = 1'b1;
                                w_lifoIn = w_wdataNext;
                            end
                        end
                        OP_POP, OP_XCH: begin
                            if (i_lifo_empty) w_errNext = 1'b1;
                            else              w_pop     = 1'b1;
                        end
                        default: w_clr = 1'b1;
                    endcase
                    w_stateNext = EXEC;
                end
            end
            EXEC: begin
                // Top of stack is still valid here; the pop takes effect at the
                // end of this cycle.
                w_capture = ((r_op == OP_POP) || (r_op == OP_XCH)) && !r_err;
                if ((r_op == OP_XCH) && !r_err) begin
                    w_clken     = 1'b1;
                    w_push      = 1'b1;
                    w_lifoIn    = r_wdata;
                    w_stateNext = XPUSH;
                end else begin
                    w_ack[r_grant]    = 1'b1;
                    w_errOut[r_grant] = r_err;
                    w_stateNext       = DONE;
                end
            end
            XPUSH: begin
                w_ack[r_grant]    = 1'b1;
                w_errOut[r_grant] = r_err;
                w_stateNext       = DONE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State, command latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_PUSH;
            r_wdata  <= '0;
            r_grant  <= 1'b0;
            r_rr     <= 1'b0;
            r_err    <= 1'b0;
            r_ack    <= 2'b00;
            r_errOut <= 2'b00;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_clken  <= 1'b0;
            r_clr    <= 1'b0;
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_lifoIn <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_op     <= w_opNext;
            r_wdata  <= w_wdataNext;
            r_grant  <= w_grantNext;
            r_rr     <= w_rrNext;
            r_err    <= w_errNext;
            r_ack    <= w_ack;
            r_errOut <= w_errOut;
            r_busy   <= (w_stateNext != IDLE);
            r_clken  <= w_clken;
            r_clr    <= w_clr;
            r_push   <= w_push;
            r_pop    <= w_pop;
            r_lifoIn <= w_lifoIn;
            if (w_capture) r_rdata <= i_lifo_out;
        end
    end

    assign bus.ack0     = r_ack[0];
    assign bus.ack1     = r_ack[1];
    assign bus.err0     = r_errOut[0];
    assign bus.err1     = r_errOut[1];
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign o_lifo_clken = r_clken;
    assign o_lifo_clr   = r_clr;
    assign o_lifo_push  = r_push;
    assign o_lifo_pop   = r_pop;
    assign o_lifo_in    = r_lifoIn;

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter
//   Directed bench for lifo_arbiter with a small 4-deep behavioural stack
//   attached. Latency is counted in cycles with the IDLE cycle in which the
//   request is first sampled as cycle 1.
module tb_lifo_arbiter;

    localparam int WIDTH = 36;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_XCH  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lifoClken;
    logic             lifoClr;
    logic             lifoPush;
    logic             lifoPop;
    logic [WIDTH-1:0] lifoIn;
    logic [WIDTH-1:0] lifoOut;
    logic             lifoFull;
    logic             lifoEmpty;

    int checkCount = 0;
    int failCount  = 0;

    lifo_arbiter_if #(.WIDTH(WIDTH)) bus ();

    lifo_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_lifo_clken (lifoClken),
        .o_lifo_clr   (lifoClr),
        .o_lifo_push  (lifoPush),
        .o_lifo_pop   (lifoPop),
        .o_lifo_in    (lifoIn),
        .i_lifo_out   (lifoOut),
        .i_lifo_full  (lifoFull),
        .i_lifo_empty (lifoEmpty)
    );

    always #5 clk = ~clk;

    // Behavioural 4-deep stack; a push on full drops the oldest entry.
    logic [WIDTH-1:0] stkMem [4];
    logic [2:0]       stkCount = 3'd0;

    always @(posedge clk) begin
        if (lifoClken) begin
            if (lifoClr) begin
                stkCount <= 3'd0;
            end else if (lifoPush) begin
                if (stkCount == 3'd4) begin
                    for (int i = 0; i < 3; i++) stkMem[i] <= stkMem[i+1];
                    stkMem[3] <= lifoIn;
                end else begin
                    stkMem[2'(stkCount)] <= lifoIn;
                    stkCount <= stkCount + 3'd1;
                end
            end else if (lifoPop && (stkCount != 3'd0)) begin
                stkCount <= stkCount - 3'd1;
            end
        end
    end

    assign lifoOut   = (stkCount != 3'd0) ? stkMem[2'(stkCount - 3'd1)] : '0;
    assign lifoFull  = (stkCount == 3'd4);
    assign lifoEmpty = (stkCount == 3'd0);

    // Strobe and ack event counters, sampled at each rising edge.
    int pushCnt   = 0;
    int popCnt    = 0;
    int clrCnt    = 0;
    int ackCnt    = 0;
    int clashCnt  = 0;
    int strayCnt  = 0;

    always @(posedge clk) begin
        if (lifoPush) pushCnt <= pushCnt + 1;
        if (lifoPop)  popCnt  <= popCnt + 1;
        if (lifoClr)  clrCnt  <= clrCnt + 1;
        if (bus.ack0 || bus.ack1) ackCnt <= ackCnt + 1;
        if (lifoPush && lifoPop) clashCnt <= clashCnt + 1;
        if ((lifoPush || lifoPop || lifoClr) && !lifoClken) strayCnt <= strayCnt + 1;
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one command on one requester; returns latency (99 on timeout),
    // the err bit seen with the ack.
    task automatic applyStimulus(input int who, input logic [1:0] op,
                                 input logic [WIDTH-1:0] data,
                                 output int lat, output logic err);
        logic got;
        @(negedge clk);
        if (who == 0) begin
            bus.op0 = op; bus.wdata0 = data; bus.req0 = 1'b1;
        end else begin
            bus.op1 = op; bus.wdata1 = data; bus.req1 = 1'b1;
        end
        lat = 1;
        got = 1'b0;
        err = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (who == 0 && bus.ack0) begin got = 1'b1; err = bus.err0; end
            if (who == 1 && bus.ack1) begin got = 1'b1; err = bus.err1; end
        end
        if (!got) lat = 99;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    int               lat;
    logic             err;
    int               snap;
    int               ackTotal;
    int               done0;
    int               done1;
    logic [7:0]       order;

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = OP_PUSH; bus.op1 = OP_PUSH;
        bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy",  64'(bus.busy), 64'd0);
        checkOutput("rst_ack",   64'({bus.ack1, bus.ack0}), 64'd0);
        checkOutput("rst_err",   64'({bus.err1, bus.err0}), 64'd0);
        checkOutput("rst_strb",  64'({lifoClken, lifoClr, lifoPush, lifoPop}), 64'd0);
        checkOutput("rst_rdata", 64'(bus.rdata), 64'd0);
        checkOutput("rst_in",    64'(lifoIn), 64'd0);

        // 1: push then pop through requester 0
        applyStimulus(0, OP_PUSH, 36'h123456789, lat, err);
        checkOutput("t1_push_lat", 64'(lat), 64'd3);
        checkOutput("t1_push_err", 64'(err), 64'd0);
        applyStimulus(0, OP_POP, '0, lat, err);
        checkOutput("t1_pop_lat",   64'(lat), 64'd3);
        checkOutput("t1_pop_err",   64'(err), 64'd0);
        checkOutput("t1_pop_rdata", 64'(bus.rdata), 64'h123456789);

        // 2: both requesters push 4x with req held; grants alternate, 0 first
        applyStimulus(0, OP_CLR, '0, lat, err);
        applyReset();
        @(negedge clk);
        bus.op0 = OP_PUSH; bus.wdata0 = 36'h0AAAA;
        bus.op1 = OP_PUSH; bus.wdata1 = 36'h1BBBB;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        ackTotal = 0; done0 = 0; done1 = 0; order = 8'h00;
        for (int c = 0; c < 100 && ackTotal < 8; c++) begin
            @(negedge clk);
            if (bus.ack0) begin
                if (ackTotal < 8) order[ackTotal] = 1'b0;
                ackTotal++; done0++;
                if (done0 == 4) bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                if (ackTotal < 8) order[ackTotal] = 1'b1;
                ackTotal++; done1++;
                if (done1 == 4) bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        checkOutput("t2_acks",  64'(ackTotal), 64'd8);
        checkOutput("t2_order", 64'(order), 64'hAA);
        checkOutput("t2_done0", 64'(done0), 64'd4);

        // 3: push A, push B, exchange C, pop, pop
        applyStimulus(1, OP_CLR, '0, lat, err);
        applyStimulus(0, OP_PUSH, 36'hA, lat, err);
        applyStimulus(0, OP_PUSH, 36'hB, lat, err);
        applyStimulus(0, OP_XCH, 36'hC, lat, err);
        checkOutput("t3_xch_lat",   64'(lat), 64'd4);
        checkOutput("t3_xch_err",   64'(err), 64'd0);
        checkOutput("t3_xch_rdata", 64'(bus.rdata), 64'hB);
        checkOutput("t3_depth",     64'(stkCount), 64'd2);
        applyStimulus(1, OP_POP, '0, lat, err);
        checkOutput("t3_pop1", 64'(bus.rdata), 64'hC);
        applyStimulus(1, OP_POP, '0, lat, err);
        checkOutput("t3_pop2", 64'(bus.rdata), 64'hA);

        // 4: pop on empty stack
        snap = popCnt;
        applyStimulus(0, OP_POP, '0, lat, err);
        checkOutput("t4_err",   64'(err), 64'd1);
        checkOutput("t4_lat",   64'(lat), 64'd3);
        checkOutput("t4_nopop", 64'(popCnt - snap), 64'd0);
        checkOutput("t4_rdata", 64'(bus.rdata), 64'hA);

        // 5: fill to full, then push D
        for (int i = 1; i <= 4; i++) applyStimulus(0, OP_PUSH, 36'(i), lat, err);
        checkOutput("t5_full", 64'(lifoFull), 64'd1);
        snap = pushCnt;
        applyStimulus(0, OP_PUSH, 36'hD, lat, err);
`ifdef LIFO_ARBITER_OVFPROT_EN
        checkOutput("t5_err",   64'(err), 64'd1);
        checkOutput("t5_pushes", 64'(pushCnt - snap), 64'd0);
        checkOutput("t5_top",   64'(lifoOut), 64'h4);
`else
        checkOutput("t5_err",   64'(err), 64'd0);
        checkOutput("t5_pushes", 64'(pushCnt - snap), 64'd1);
        checkOutput("t5_top",   64'(lifoOut), 64'hD);
`endif

        // 6: reset during XPUSH, then clear from requester 1
        @(negedge clk);
        bus.op0 = OP_XCH; bus.wdata0 = 36'hE; bus.req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_xpush", 64'(lifoPush), 64'd1);
        snap = ackCnt;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_busy",  64'(bus.busy), 64'd0);
        checkOutput("t6_ack",   64'({bus.ack1, bus.ack0}), 64'd0);
        checkOutput("t6_strb",  64'({lifoClken, lifoClr, lifoPush, lifoPop}), 64'd0);
        checkOutput("t6_rdata", 64'(bus.rdata), 64'd0);
        checkOutput("t6_in",    64'(lifoIn), 64'd0);
        bus.req0 = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t6_noack", 64'(ackCnt - snap), 64'd0);
        snap = clrCnt;
        applyStimulus(1, OP_CLR, '0, lat, err);
        checkOutput("t6_clr_lat", 64'(lat), 64'd3);
        checkOutput("t6_clr_err", 64'(err), 64'd0);
        checkOutput("t6_clrs",    64'(clrCnt - snap), 64'd1);
        checkOutput("t6_empty",   64'(lifoEmpty), 64'd1);

        // Whole-run stack strobe sanity
        checkOutput("push_pop_clash", 64'(clashCnt), 64'd0);
        checkOutput("strobe_no_clken", 64'(strayCnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
